// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the inverse cipher.
// Optional build macro used by the engine: AES_INV_ZEROIZE_EN.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef logic [3:0]           rnd_t;
  typedef logic [AES_BLK_W-1:0] blk_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } fsm_t;

  // MSB position of state byte (row r, column c) in a 128-bit block
  function automatic int bpos(int r, int c);
    return 127 - 8 * (4 * c + r);
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // multiply by a 4-bit constant (0x09, 0x0b, 0x0d, 0x0e)
  function automatic logic [7:0] gmul(logic [7:0] a, logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a  : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^
           (k[3] ? x8 : 8'h00);
  endfunction

  // one column of InvMixColumns, row 0 in the top byte
  function automatic logic [31:0] inv_mix_col(logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {
      gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
      gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
      gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
      gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
    };
  endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Block-in / block-out handshake bundle plus round-key lookup port.
// The engine is the slave; the block source / key store is the master.
interface aes_inv_cipher_if;
  import aes_pkg::*;

  logic in_valid;
  logic in_ready;
  blk_t in_data;
  rnd_t rk_idx;
  blk_t rk_data;
  logic out_valid;
  logic out_ready;
  blk_t out_data;

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );

endinterface

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box, purely combinational 256-entry lookup.
// Entry 0 sits in the top byte of the table constant.
module aes_inv_sbox (
  input  logic [7:0] sbox_i,
  output logic [7:0] sbox_o
);

  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // entry a lives at bit offset 8*(255-a)
  assign sbox_o = TBL[{~sbox_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Build macro AES_INV_ZEROIZE_EN clears the state after hand-off.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  aes_inv_cipher_if.slave bus
);

  fsm_t fsm_q, fsm_d;
  blk_t st_q, st_d;
  rnd_t cnt_q, cnt_d;

  blk_t sh;
  blk_t sb;
  blk_t ark;
  blk_t imc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sh[bpos(r, c) -: 8] =
        st_q[bpos(r, (c + 4 - r) % 4) -: 8];
      aes_inv_sbox u_sbox (
        .sbox_i (sh[bpos(r, c) -: 8]),
        .sbox_o (sb[bpos(r, c) -: 8])
      );
    end
    assign imc[bpos(0, c) -: 32] =
      inv_mix_col(ark[bpos(0, c) -: 32]);
  end

  assign ark = sb ^ bus.rk_data;

  // state, round counter and FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // next state: load, iterate rounds, hand off
  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          st_d  = bus.in_data ^ bus.rk_data;
          cnt_d = rnd_t'(AES_NR - 1);
          fsm_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (cnt_q == '0) begin
          st_d  = ark;
          fsm_d = S_DONE;
        end else begin
          st_d  = imc;
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          fsm_d = S_IDLE;
`ifdef AES_INV_ZEROIZE_EN
          st_d  = '0;
`else
          st_d  = st_q;
`endif
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // outputs decoded from FSM state only
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.rk_idx    = '0;
    unique case (fsm_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        bus.rk_idx   = rnd_t'(AES_NR);
      end
      S_ROUND: bus.rk_idx = cnt_q;
      S_DONE:  bus.out_valid = 1'b1;
      default: bus.rk_idx = '0;
    endcase
  end

  assign bus.out_data = st_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher against a byte-level model.
// Honours AES_INV_ZEROIZE_EN for the post-handshake data check.
module tb_aes_inv_cipher;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_inv_cipher_if bus ();

  aes_inv_cipher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] sb_a;
  logic [7:0] sb_d;
  aes_inv_sbox u_sb (
    .sbox_i (sb_a),
    .sbox_o (sb_d)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   fsb [0:255];
  logic [7:0]   isb [0:255];
  logic [127:0] rk  [0:10];

  always_comb begin
    bus.rk_data = '0;
    if (bus.rk_idx <= 4'd10) bus.rk_data = rk[bus.rk_idx];
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from field inverse plus affine map; inverse box by inversion
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
        ^ rotl(inv, 4) ^ 8'h63;
      fsb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] w);
    return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
  endfunction

  task automatic key_exp(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] ref_dec(logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] k, o;
    k = rk[10];
    for (int i = 0; i < 16; i++)
      s[i] = ct[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4 * c] = isb[s[r + 4 * ((c + 4 - r) % 4)]];
      k = rk[rnd];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[127 - 8 * i -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c];
          a1 = s[4 * c + 1];
          a2 = s[4 * c + 2];
          a3 = s[4 * c + 3];
          s[4 * c]     = gm(a0, 8'h0e) ^ gm(a1, 8'h0b)
                       ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
          s[4 * c + 1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e)
                       ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
          s[4 * c + 2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09)
                       ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
          s[4 * c + 3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d)
                       ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // one block: accept, track rk_idx, optional backpressure, hand-off
  task automatic run_blk(input logic [127:0] ct, input int hold,
                         output logic [127:0] pt);
    int n;
    logic [39:0]  seq, exq;
    logic [127:0] hd, pexp;
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 128'(bus.in_ready), 128'(1));
    chk("rk_idx_idle", 128'(bus.rk_idx), 128'(10));
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    @(negedge clk);
    n = 0;
    seq = '0;
    while (!bus.out_valid && n < 30) begin
      seq = {seq[35:0], bus.rk_idx};
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = rnd128();
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    exq = '0;
    for (int k = 9; k >= 0; k--) exq = {exq[35:0], 4'(k)};
    chk("latency", 128'(n), 128'(10));
    chk("rk_seq", 128'(seq), 128'(exq));
    chk("rk_idx_done", 128'(bus.rk_idx), 128'(0));
    chk("in_ready_done", 128'(bus.in_ready), 128'(0));
    pt = bus.out_data;
    hd = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rnd128();
      @(negedge clk);
      chk("hold_data", bus.out_data, hd);
      chk("hold_valid", 128'(bus.out_valid), 128'(1));
      chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    if (hold > 0) bus.out_ready = 1'b0;
`ifdef AES_INV_ZEROIZE_EN
    pexp = '0;
`else
    pexp = hd;
`endif
    chk("post_valid", 128'(bus.out_valid), 128'(0));
    chk("post_in_ready", 128'(bus.in_ready), 128'(1));
    chk("post_data", bus.out_data, pexp);
  endtask

  logic [127:0] ct, pt;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int r = 0; r <= 10; r++) rk[r] = '0;
    build_tables();

    sb_a = 8'h63;
    #1 chk("sbox_63", 128'(sb_d), 128'(8'h00));
    sb_a = 8'h00;
    #1 chk("sbox_00", 128'(sb_d), 128'(8'h52));
    for (int x = 0; x < 256; x++) begin
      sb_a = 8'(x);
      #1 chk("sbox_sweep", 128'(sb_d), 128'(isb[x]));
    end

    #1 chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'(10));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));

    key_exp(128'h000102030405060708090a0b0c0d0e0f);
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    run_blk(ct, 0, pt);
    chk("fips_c1", pt, 128'h00112233445566778899aabbccddeeff);
    chk("model_c1", pt, ref_dec(ct));

    key_exp(128'h2b7e151628aed2a6abf7158809cf4f3c);
    ct = 128'h3925841d02dc09fbdc118597196a0b32;
    run_blk(ct, 5, pt);
    chk("fips_b", pt, 128'h3243f6a8885a308d313198a2e0370734);

    key_exp(rnd128());
    for (int b = 0; b < 4; b++) begin
      ct = rnd128();
      run_blk(ct, 0, pt);
      chk("b2b_block", pt, ref_dec(ct));
    end
    bus.out_ready = 1'b0;

    ct = rnd128();
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_round_busy", 128'(bus.in_ready), 128'(0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_out_data", bus.out_data, '0);
    chk("mid_rst_rk_idx", 128'(bus.rk_idx), 128'(10));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_idle_valid", 128'(bus.out_valid), 128'(0));

    ct = rnd128();
    run_blk(ct, 2, pt);
    chk("after_rst_block", pt, ref_dec(ct));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
